// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

  localparam int unsigned NibbleW    = 4;
  localparam int unsigned NibblesDef = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub port exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned Width = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rc_adder.sv
// 4-bit ripple-carry adder built from explicit full-adder gates.
// Also exposes the carry into the MSB so callers can derive signed overflow.
module rc_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       c_msb_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c1 = g[0] | (p[0] & cin_i);
  assign c2 = g[1] | (p[1] & c1);
  assign c3 = g[2] | (p[2] & c2);

  assign sum_o   = p ^ {c3, c2, c1, cin_i};
  assign cout_o  = g[3] | (p[3] & c3);
  assign c_msb_o = c3;

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: latches operands, adds one nibble per RUN cycle via rc_adder.
// Optional SERIAL_ADD_SUB_EN adds a sub input computing a + ~b + 1.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned NIBBLES = NibblesDef
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int unsigned W    = NibbleW * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic [W-1:0]    b_eff;
  logic            cin_eff;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_s;
  logic            nib_co;
  logic            nib_c3;

  // Subtraction is folded in at acceptance: store ~b and force the initial carry to 1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign nib_a = a_q[idx_q*NibbleW +: NibbleW];
  assign nib_b = b_q[idx_q*NibbleW +: NibbleW];

  rc_adder u_rc_adder (
    .a_i     (nib_a),
    .b_i     (nib_b),
    .cin_i   (carry_q),
    .sum_o   (nib_s),
    .cout_o  (nib_co),
    .c_msb_o (nib_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= b_eff;
            carry_q    <= cin_eff;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          sum_q[idx_q*NibbleW +: NibbleW] <= nib_s;
          carry_q                         <= nib_co;
          if (idx_q == LastIdx) begin
            cout_q  <= nib_co;
            ovf_q   <= nib_co ^ nib_c3;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        StDone: begin
          // First DONE cycle only raises out_valid; the handshake is taken from then on.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl; define SERIAL_ADD_SUB_EN to also cover subtraction.
module tb_serial_add_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  serial_add_ctrl_if #(.Width(W)) bus ();

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   full;
    bb     = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Drives one operand set; returns right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
    end
    if (push) sb.push_back(model(a, b, cin, sub));
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub      = sub;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble inputs to show latched operands are used.
    bus.a        = ~a;
    bus.b        = ~b;
    bus.cin      = ~cin;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   cnt;
    logic [W-1:0] s0;
    cnt = 0;
    bus.out_ready = (hold == 0);
    while (cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.out_valid === 1'b1) break;
    end
    e = sb.pop_front();
    checks++;
    if (cnt != N + 1) begin
      errors++;
      $display("FAIL latency: out_valid after %0d edges required %0d", cnt, N + 1);
      bus.out_ready = 1'b1;
      return;
    end
    checks++;
    if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
      errors++;
      $display("FAIL result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_in_ready: in_ready=%b required 0", bus.in_ready);
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== e.sum ||
          bus.cout !== e.cout || bus.ovf !== e.ovf) begin
        errors++;
        $display("FAIL hold[%0d]: valid=%b ready=%b sum=%h cout=%b ovf=%b required 1 0 %h %b %b",
                 i, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf,
                 e.sum, e.cout, e.ovf);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    s0 = bus.sum;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || s0 !== e.sum) begin
      errors++;
      $display("FAIL handshake: valid=%b ready=%b sum=%h required 0 1 %h",
               bus.out_valid, bus.in_ready, s0, e.sum);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 ||
        bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_vectors();
    send(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);
    collect(0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    collect(0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    collect(0);
    send(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_backpressure();
    send(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 1'b1);
    collect(10);
    // The in_valid pulse seen during DONE must not have started an operation.
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ignored_pulse[%0d]: valid=%b ready=%b required 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 ||
        bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: ready=%b valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_valid[%0d]: out_valid=%b required 0", i, bus.out_valid);
      end
    end
    send(16'h0003, 16'h0004, 1'b1, 1'b0, 1'b1);
    collect(0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      send(a, b, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      collect(0);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    collect(0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    collect(0);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
    collect(0);
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;
    test_reset();
    test_add_vectors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4; operand width W = 4*NIBBLES bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand set valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  W  first operand.
REQ-007 SHALL have port b  input  W  second operand.
REQ-008 SHALL have port cin  input  1  carry-in to nibble 0.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  W  registered result.
REQ-012 SHALL have port cout  output  1  carry out of the top nibble.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow of the W-bit result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1.
- IDLE->RUN on in_valid&&in_ready.
- RUN->DONE after NIBBLES RUN cycles.
- DONE->IDLE on out_valid&&out_ready.
REQ-015 SHALL latch a, b and cin on acceptance, clear the nibble index to 0, and ignore input changes afterwards.
REQ-016 SHALL, in each RUN cycle i (0..NIBBLES-1), feed nibble i of the latched a and b plus the carry register into one 4-bit ripple-carry adder.
- SHALL write the 4-bit adder sum into sum[4i+3:4i].
- SHALL load the adder carry-out into the carry register.
REQ-017 SHALL take cin as the carry into nibble 0.
REQ-018 SHALL register cout as the carry out of nibble NIBBLES-1.
REQ-019 SHALL register ovf as the carry into the MSB XOR the carry out of the MSB, taken from the top nibble.
REQ-020 SHALL assert out_valid only in DONE, so out_valid first rises NIBBLES+1 edges after the accepting edge.
REQ-021 SHALL hold sum, cout and ovf stable while out_valid=1 and out_ready=0, for unlimited backpressure.
REQ-022 SHALL keep in_ready=0 in RUN and DONE, including the DONE handshake cycle; the next accept is no earlier than the cycle after returning to IDLE.
REQ-023 SHALL leave sum, cout and ovf at their last values in IDLE.
REQ-024 SHALL show partial nibble results on sum during RUN; these are not valid.
REQ-025 SHALL wrap the nibble index only via the RUN->DONE transition and never index beyond NIBBLES-1.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register=0 and nibble index=0.
REQ-027 SHALL abort an operation cleanly when reset is asserted mid-RUN or mid-DONE: no out_valid pulse after release, and the next accepted operation computes correctly.

Configuration
REQ-028 SHALL support the macro SERIAL_ADD_SUB_EN.
- Defined: SHALL add input port sub (1 bit), latched on acceptance; sub=1 computes a + ~b + 1 with cin ignored; cout=1 means no borrow; ovf uses the same rule on the inverted operand.
- Undefined: SHALL have no sub port and compute a + b + cin only.

Structure
REQ-029 SHALL take the FSM state enum (IDLE/RUN/DONE), the nibble width constant 4 and the default NIBBLES from shared package serial_add_pkg.
REQ-030 SHALL instantiate the existing 4-bit ripple-carry adder, rc_adder, as its single sub-module; no other arithmetic is inferred.

Verification
REQ-031 SHALL cover a=0x1234, b=0x0FCD, cin=0 -> after 5 edges out_valid=1, sum=0x2201, cout=0, ovf=0.
REQ-032 SHALL cover a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 SHALL cover holding out_ready=0 for 10 cycles after out_valid -> sum, cout and ovf are unchanged, in_ready=0 throughout, and a new in_valid pulse is ignored.
REQ-034 SHALL cover asserting rst_n=0 on the 2nd RUN cycle -> all outputs at reset values, no out_valid afterwards; then 0x0003+0x0004, cin=1 -> sum=0x0008.
REQ-035 SHALL cover, with SERIAL_ADD_SUB_EN, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
REQ-036 SHALL cover, with SERIAL_ADD_SUB_EN, sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
